// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, opcode map,
// one-hot control encodings and the long-op classifier.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT,
    ST_FAULT
  } state_e;

  localparam int CTRL_W = 11;

  localparam logic [3:0] OP_S0  = 4'b0000;
  localparam logic [3:0] OP_S1  = 4'b0001;
  localparam logic [3:0] OP_S2  = 4'b0010;
  localparam logic [3:0] OP_S3  = 4'b0011;
  localparam logic [3:0] OP_S4  = 4'b0100;
  localparam logic [3:0] OP_S5  = 4'b0110;
  localparam logic [3:0] OP_S6  = 4'b0111;
  localparam logic [3:0] OP_S7  = 4'b1000;
  localparam logic [3:0] OP_S8  = 4'b1100;
  localparam logic [3:0] OP_S9  = 4'b1001;
  localparam logic [3:0] OP_S10 = 4'b1111;

  localparam logic [CTRL_W-1:0] CTRL_S0  = 11'h001;
  localparam logic [CTRL_W-1:0] CTRL_S1  = 11'h002;
  localparam logic [CTRL_W-1:0] CTRL_S2  = 11'h004;
  localparam logic [CTRL_W-1:0] CTRL_S3  = 11'h008;
  localparam logic [CTRL_W-1:0] CTRL_S4  = 11'h010;
  localparam logic [CTRL_W-1:0] CTRL_S5  = 11'h020;
  localparam logic [CTRL_W-1:0] CTRL_S6  = 11'h040;
  localparam logic [CTRL_W-1:0] CTRL_S7  = 11'h080;
  localparam logic [CTRL_W-1:0] CTRL_S8  = 11'h100;
  localparam logic [CTRL_W-1:0] CTRL_S9  = 11'h200;
  localparam logic [CTRL_W-1:0] CTRL_S10 = 11'h400;

  // s7, s8 and s9 drive the slow datapath paths and need the extended EXEC window
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_S7) || (op == OP_S8) || (op == OP_S9);
  endfunction

endpackage

// File: rtl/opcode_onehot_dec.sv
// Combinational opcode decoder: 4-bit opcode to 11-way one-hot control vector,
// with illegal-opcode and HALT flags.
module opcode_onehot_dec
  import instr_seq_pkg::*;
(
  input  logic [3:0]        opcode,
  output logic [CTRL_W-1:0] onehot,
  output logic              illegal,
  output logic              is_halt
);

  always_comb begin
    onehot  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_S0:   onehot = CTRL_S0;
      OP_S1:   onehot = CTRL_S1;
      OP_S2:   onehot = CTRL_S2;
      OP_S3:   onehot = CTRL_S3;
      OP_S4:   onehot = CTRL_S4;
      OP_S5:   onehot = CTRL_S5;
      OP_S6:   onehot = CTRL_S6;
      OP_S7:   onehot = CTRL_S7;
      OP_S8:   onehot = CTRL_S8;
      OP_S9:   onehot = CTRL_S9;
      OP_S10:  onehot = CTRL_S10;
      default: illegal = 1'b1;
    endcase
    is_halt = (opcode == OP_S10);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM owning pc, ir and the registered ctrl vector.
// Optional INSTR_SEQ_RETIRE_CNT_EN adds a saturating retired-instruction counter output.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int LONG_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [3:0]        mem_data,
  output logic              mem_req,
  output logic [PC_W-1:0]   pc,
  output logic [CTRL_W-1:0] ctrl,
  output logic              busy,
  output logic              halted,
  output logic              illegal
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  localparam int CNT_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_CYC - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [3:0]        ir_q, ir_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_exec;
  logic              start_accept;

  logic [CTRL_W-1:0] dec_onehot;
  logic              dec_illegal;
  logic              dec_halt;

  opcode_onehot_dec u_dec (
    .opcode  (ir_q),
    .onehot  (dec_onehot),
    .illegal (dec_illegal),
    .is_halt (dec_halt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  // ctrl_d defaults to zero so ctrl drops on leaving EXEC and after the single s10 HALT cycle
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ctrl_d       = '0;
    cnt_d        = cnt_q;
    last_exec    = 1'b0;
    start_accept = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = ST_FETCH;
          pc_d         = '0;
        end
      end
      ST_FETCH: begin
        if (mem_rdy) begin
          ir_d    = mem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_FAULT;
        end else if (dec_halt) begin
          state_d = ST_HALT;
          ctrl_d  = dec_onehot;
        end else begin
          state_d = ST_EXEC;
          ctrl_d  = dec_onehot;
          cnt_d   = is_long_op(ir_q) ? LONG_LOAD : '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          last_exec = 1'b1;
          pc_d      = pc_q + PC_W'(1);
          state_d   = ST_FETCH;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          ctrl_d = ctrl_q;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == ST_FETCH);
    busy    = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
    halted  = (state_q == ST_HALT);
    illegal = (state_q == ST_FAULT);
  end

  assign pc   = pc_q;
  assign ctrl = ctrl_q;

`ifdef INSTR_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (start_accept) begin
      retired_d = '0;
    end else if (last_exec && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule
